// File: rtl/widthcb_pipe.sv
// widthcb_pipe: Cb-axis width W_Cb(Y) of the skin-tone chroma cluster.
// Latency: 2 cycles, one sample per cycle, fully pipelined.
// Backpressure: none; out_valid is y_valid delayed by 2 cycles, no stall.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (clears both pipeline stages)
//   y_valid   y is valid this cycle
//   y         luma sample, unsigned 0..255
//   out_valid out is valid this cycle
//   out       W_Cb(Y), unsigned Q(OUT_W-FRAC_W).FRAC_W; holds when out_valid = 0
//
// Optional build macro: WIDTHCB_MIDBAND_WCB_EN
//   defined   -> mid band (125 < Yc < 188) outputs W_Cb = 46.97 (continuous curve)
//   undefined -> mid band outputs 0
module widthcb_pipe #(
   parameter int OUT_W  = 16,
   parameter int FRAC_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             y_valid,
   input  logic [7:0]       y,
   output logic             out_valid,
   output logic [OUT_W-1:0] out
);

   // Band limits and clamp range in luma codes.
   localparam logic [7:0] Y_MIN = 8'd16;
   localparam logic [7:0] Y_MAX = 8'd235;
   localparam logic [7:0] K_L   = 8'd125;
   localparam logic [7:0] K_H   = 8'd188;

   // Slopes in Q0.16: 23.97/109 and 32.97/47.
   localparam logic [31:0] SLOPE_LO = 32'd14412;
   localparam logic [31:0] SLOPE_HI = 32'd45973;

   // Band bases aligned to Q8.16.
   localparam logic [31:0] BASE_LO = 32'd23 << 16;
   localparam logic [31:0] BASE_HI = 32'd14 << 16;

   // 46.97 in Q8.16 (3078225.9 rounded), used for the continuous mid band.
   localparam logic [31:0] WCB_Q16 = 32'd3078226;

   // Q8.16 -> Q.FRAC_W conversion with round half-up.
   localparam int          SHIFT   = 16 - FRAC_W;
   localparam logic [31:0] RND     = (SHIFT > 0) ? (32'd1 << (SHIFT - 1)) : 32'd0;
   localparam logic [31:0] OUT_MAX = (OUT_W >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << OUT_W) - 32'd1);

   typedef enum logic [1:0] {
      BAND_LOW  = 2'd0,
      BAND_MID  = 2'd1,
      BAND_HIGH = 2'd2
   } band_t;

   // ---------------- Stage 1: clamp, band select, offset ----------------
   logic [7:0] yc;
   band_t      band_c;
   logic [6:0] offset_c;

   always_comb begin
      yc       = y;
      band_c   = BAND_MID;
      offset_c = 7'd0;

      if (y < Y_MIN)
         yc = Y_MIN;
      else if (y > Y_MAX)
         yc = Y_MAX;

      // Offsets are measured from the band's anchor so both products start
      // at zero: low band from Y_MIN upward, high band from Y_MAX downward.
      if (yc <= K_L) begin
         band_c   = BAND_LOW;
         offset_c = 7'(yc - Y_MIN);
      end else if (yc >= K_H) begin
         band_c   = BAND_HIGH;
         offset_c = 7'(Y_MAX - yc);
      end
   end

   // band + offset fully encode Yc for everything downstream needs.
   logic       s1_valid;
   band_t      s1_band;
   logic [6:0] s1_offset;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_band   <= BAND_MID;
         s1_offset <= 7'd0;
      end else begin
         s1_valid  <= y_valid;
         s1_band   <= band_c;
         s1_offset <= offset_c;
      end
   end

   // ---------------- Stage 2: multiply, add base, round, saturate ----------------
   logic [31:0] sum_q16;
   logic [31:0] rounded;
   logic [OUT_W-1:0] result;

   always_comb begin
      sum_q16 = 32'd0;
      case (s1_band)
         BAND_LOW:  sum_q16 = 32'(s1_offset) * SLOPE_LO + BASE_LO;
         BAND_HIGH: sum_q16 = 32'(s1_offset) * SLOPE_HI + BASE_HI;
         default: begin
`ifdef WIDTHCB_MIDBAND_WCB_EN
            sum_q16 = WCB_Q16;
`else
            sum_q16 = 32'd0;
`endif
         end
      endcase

      rounded = (sum_q16 + RND) >> SHIFT;

      if (rounded > OUT_MAX)
         result = OUT_MAX[OUT_W-1:0];
      else
         result = rounded[OUT_W-1:0];
   end

   // out only loads on a valid sample so it holds its last value otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid)
            out <= result;
      end
   end

endmodule

// File: tb/tb_widthcb_pipe.sv
// Bench for widthcb_pipe: directed, sweep and random luma samples checked
// against a real-valued formula model (+-1 LSB) delayed by two cycles.
module tb_widthcb_pipe;

   localparam int OUT_W  = 16;
   localparam int FRAC_W = 10;

   logic             clk;
   logic             rst;
   logic             y_valid;
   logic [7:0]       y;
   logic             out_valid;
   logic [OUT_W-1:0] out;

   int compared;
   int mismatched;

   // Two-deep delay line of sampled inputs (d1 = previous edge, d2 = two edges ago).
   logic d1_v, d2_v;
   int   d1_y, d2_y;
   real  last_exp;

   widthcb_pipe #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .y_valid   (y_valid),
      .y         (y),
      .out_valid (out_valid),
      .out       (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Real-valued W_Cb(Y) in output LSBs.
   function automatic real ref_lsb(input int yy);
      int  yc;
      real v;
      yc = (yy < 16) ? 16 : ((yy > 235) ? 235 : yy);
      if (yc <= 125)
         v = 23.0 + real'(yc - 16) * 23.97 / 109.0;
      else if (yc >= 188)
         v = 14.0 + real'(235 - yc) * 32.97 / 47.0;
      else begin
`ifdef WIDTHCB_MIDBAND_WCB_EN
         v = 46.97;
`else
         v = 0.0;
`endif
      end
      return v * real'(1 << FRAC_W);
   endfunction

   function automatic logic in_tol(input int obs, input real expv);
      return ((real'(obs) >= expv - 1.0) && (real'(obs) <= expv + 1.0)) ? 1'b1 : 1'b0;
   endfunction

   task automatic clear_model();
      d1_v = 1'b0;
      d2_v = 1'b0;
      d1_y = 0;
      d2_y = 0;
      last_exp = 0.0;
   endtask

   // Drive one cycle, then check out_valid/out against the model.
   task automatic step(input logic v, input logic [7:0] yy, input string tag);
      logic ok;
      int   yc;
      @(negedge clk);
      y_valid = v;
      y       = yy;
      @(posedge clk);
      #1;
      if (rst) begin
         d1_v = 1'b0;
         d2_v = 1'b0;
      end else begin
         d2_v = d1_v;
         d2_y = d1_y;
         d1_v = v;
         d1_y = int'(yy);
      end
      if (d2_v) last_exp = ref_lsb(d2_y);

      compared++;
      assert (out_valid === d2_v) else begin
         mismatched++;
         $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, d2_v);
      end

      ok = in_tol(int'(out), last_exp);
      compared++;
      assert (ok === 1'b1) else begin
         mismatched++;
         $error("FAIL %s out observed=%0d expected=%0.2f (+-1) for y=%0d",
                tag, out, last_exp, d2_y);
      end

      // Clamp ends land on exact codes: 23.0 and 14.0.
      yc = (d2_y < 16) ? 16 : ((d2_y > 235) ? 235 : d2_y);
      if (d2_v && (yc == 16 || yc == 235)) begin
         compared++;
         assert (int'(out) === ((yc == 16) ? 23 : 14) * (1 << FRAC_W)) else begin
            mismatched++;
            $error("FAIL %s exact out observed=%0d expected=%0d", tag, out,
                   ((yc == 16) ? 23 : 14) * (1 << FRAC_W));
         end
      end
   endtask

   int directed [13] = '{16, 70, 125, 188, 235, 211, 126, 150, 187, 0, 15, 236, 255};

   initial begin
      compared   = 0;
      mismatched = 0;
      clear_model();
      rst     = 1'b1;
      y_valid = 1'b0;
      y       = 8'd0;

      // Reset state.
      #12;
      compared++;
      assert (out_valid === 1'b0 && out === '0) else begin
         mismatched++;
         $error("FAIL reset_state out_valid=%0b out=%0d expected 0/0", out_valid, out);
      end
      @(negedge clk);
      rst = 1'b0;

      // Directed points, back-to-back, then gaps to see the hold behaviour.
      foreach (directed[i]) step(1'b1, 8'(directed[i]), "directed");
      step(1'b0, 8'd77, "drain");
      step(1'b0, 8'd77, "drain");
      step(1'b0, 8'd99, "hold");

      // Full sweep with y_valid held high.
      for (int i = 0; i < 256; i++) step(1'b1, 8'(i), "sweep");
      step(1'b0, 8'd0, "drain");
      step(1'b0, 8'd0, "drain");

      // Random valid pattern and luma values.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), "random");

      // Asynchronous reset mid-stream with samples in flight.
      step(1'b1, 8'd100, "pre_rst");
      step(1'b1, 8'd200, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      compared++;
      assert (out_valid === 1'b0 && out === '0) else begin
         mismatched++;
         $error("FAIL async_rst out_valid=%0b out=%0d expected 0/0", out_valid, out);
      end
      clear_model();
      step(1'b1, 8'd60, "in_rst");
      step(1'b0, 8'd0, "in_rst");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 8'd0, "post_rst");
      step(1'b0, 8'd0, "post_rst");
      step(1'b1, 8'd16, "post_rst_first");
      step(1'b0, 8'd0, "post_rst_lat1");
      step(1'b0, 8'd0, "post_rst_lat2");
      compared++;
      assert (out_valid === 1'b0 && out === 16'd23552) else begin
         mismatched++;
         $error("FAIL post_rst_value out_valid=%0b out=%0d expected 0/23552", out_valid, out);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
